compress_block: RTL and testbench

Forward-path counterpart of the per-block decompressor. It accepts one 8x8 block of unsigned pixels and level-shifts them. It computes an orthonormal 2D DCT-II as a sequential separable transform: a row pass, then a column pass, one output element per cycle. It then quantizes each coefficient with a per-position power-of-two shift and presents the signed coefficients in the same [row][col] array form the decompressor consumes.

---
 rtl/compress_block_if.sv | 24 ++
 rtl/compress_block.sv | 181 ++++++++++++++++++
 tb/tb_compress_block.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/compress_block_if.sv
// Block-level bundle between a pixel source and compress_block: start request,
// the captured pixel/shift arrays, and the quantized result with its status.
interface compress_block_if #(
    parameter int BLOCK_SIZE  = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int COEFF_WIDTH = 9
);
    logic                                                          start_block;
    logic        [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][PIXEL_WIDTH-1:0] pixels_in;
    logic        [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][3:0]             quant_shift;
    logic signed [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][COEFF_WIDTH-1:0] quantized_coeffs_out;
    logic                                                          block_done;
    logic                                                          busy;

    modport master (
        output start_block, pixels_in, quant_shift,
        input  quantized_coeffs_out, block_done, busy
    );

    modport slave (
        input  start_block, pixels_in, quant_shift,
        output quantized_coeffs_out, block_done, busy
    );
endinterface

// File: rtl/compress_block.sv
// 8x8 forward DCT-II (row pass then column pass, one element per cycle) followed by
// per-coefficient power-of-two quantization with rounding and saturation.
module compress_block #(
    parameter int BLOCK_SIZE  = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int COEFF_WIDTH = 9,
    parameter int COS_WIDTH   = 12
) (
    input logic             clk,
    input logic             rst,
    compress_block_if.slave bus
);
    localparam int N         = BLOCK_SIZE * BLOCK_SIZE;
    localparam int IDX_W     = $clog2(BLOCK_SIZE);
    localparam int K_W       = 2 * IDX_W;
    localparam int SAMPLE_W  = PIXEL_WIDTH + 1;
    localparam int T_W       = 12;
    localparam int QW        = T_W + 1;
    localparam int PROD_W    = T_W + COS_WIDTH;
    localparam int ACC_W     = PROD_W + 4;
    localparam int FRAC_W    = COS_WIDTH - 1;
    localparam int MAX_SHIFT = 11;

    localparam logic [K_W-1:0]          K_LAST     = '1;
    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1 << (FRAC_W - 1));
    localparam logic signed [QW-1:0]    Q_MAX      = QW'((1 << (COEFF_WIDTH - 1)) - 1);
    localparam logic signed [QW-1:0]    Q_MIN      = QW'(-(1 << (COEFF_WIDTH - 1)));

    typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_t;

    state_t                      state;
    state_t                      state_next;
    logic                        accept;
    logic [K_W-1:0]              k;
    logic [IDX_W-1:0]            k_hi;
    logic [IDX_W-1:0]            k_lo;
    logic signed [SAMPLE_W-1:0]  samples [N];
    logic [3:0]                  shifts  [N];
    logic signed [T_W-1:0]       row_res [N];
    logic signed [COEFF_WIDTH-1:0] res   [N];

    logic signed [T_W-1:0]       operand;
    logic signed [COS_WIDTH-1:0] coef;
    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_W-1:0]     acc;
    logic signed [T_W-1:0]       f_val;
    logic signed [COEFF_WIDTH-1:0] q_val;

    // Q1.11 DCT basis; folds the angle into the first quadrant of cos(m*pi/16).
    function automatic logic signed [COS_WIDTH-1:0] cos_rom(input int u, input int x);
        int   m;
        int   mag;
        logic neg;
        m = ((2 * x + 1) * u) % 32;
        if (m > 16) m = 32 - m;
        neg = (m > 8);
        if (neg) m = 16 - m;
        case (m)
            0:       mag = 1024;
            1:       mag = 1004;
            2:       mag = 946;
            3:       mag = 851;
            4:       mag = 724;
            5:       mag = 569;
            6:       mag = 392;
            7:       mag = 200;
            default: mag = 0;
        endcase
        if (u == 0) mag = 724;
        return COS_WIDTH'(neg ? -mag : mag);
    endfunction

    function automatic logic signed [T_W-1:0] round_q(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] shifted;
        shifted = (a + ROUND_HALF) >>> FRAC_W;
        return shifted[T_W-1:0];
    endfunction

    function automatic logic signed [QW-1:0] quantize(input logic signed [T_W-1:0] f,
                                                      input logic [3:0] sh);
        logic signed [QW-1:0] bias;
        logic signed [QW-1:0] biased;
        bias = '0;
        if (sh != 4'd0) bias[sh - 4'd1] = 1'b1;
        biased = QW'(f) + bias;
        return biased >>> sh;
    endfunction

    function automatic logic signed [COEFF_WIDTH-1:0] saturate(input logic signed [QW-1:0] val);
        logic signed [QW-1:0] clipped;
        if (val > Q_MAX)      clipped = Q_MAX;
        else if (val < Q_MIN) clipped = Q_MIN;
        else                  clipped = val;
        return clipped[COEFF_WIDTH-1:0];
    endfunction

    assign k_hi = k[K_W-1:IDX_W];
    assign k_lo = k[IDX_W-1:0];

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (bus.start_block) begin
                state_next = ROW;
                accept     = 1'b1;
            end
            ROW:     if (k == K_LAST) state_next = COL;
            COL:     if (k == K_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            k              <= '0;
            bus.busy       <= 1'b0;
            bus.block_done <= 1'b0;
        end else begin
            state          <= state_next;
            k              <= (state == ROW || state == COL) ? k + K_W'(1) : '0;
            bus.busy       <= (state_next != IDLE);
            bus.block_done <= (state == COL) && (k == K_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                samples[i] <= SAMPLE_W'({1'b0, bus.pixels_in[i / BLOCK_SIZE][i % BLOCK_SIZE]})
                              - SAMPLE_W'(128);
                shifts[i]  <= (bus.quant_shift[i / BLOCK_SIZE][i % BLOCK_SIZE] > 4'(MAX_SHIFT))
                              ? 4'(MAX_SHIFT) : bus.quant_shift[i / BLOCK_SIZE][i % BLOCK_SIZE];
            end
        end
    end

    // One dot product per cycle: row pass walks s[r][*], column pass walks T[*][u].
    always_comb begin
        acc     = '0;
        operand = '0;
        coef    = '0;
        prod    = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (state == COL) begin
                operand = row_res[{IDX_W'(i), k_lo}];
                coef    = cos_rom(int'(k_hi), i);
            end else begin
                operand = T_W'(samples[{k_hi, IDX_W'(i)}]);
                coef    = cos_rom(int'(k_lo), i);
            end
            prod = PROD_W'(operand) * PROD_W'(coef);
            acc  = acc + ACC_W'(prod);
        end
    end

    assign f_val = round_q(acc);
    assign q_val = saturate(quantize(f_val, shifts[k]));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                row_res[i] <= '0;
                res[i]     <= '0;
            end
            bus.quantized_coeffs_out <= '0;
        end else if (state == ROW) begin
            row_res[k] <= f_val;
        end else if (state == COL) begin
            res[k] <= q_val;
            // Last coefficient bypasses R so the whole block publishes on the DONE edge.
            if (k == K_LAST) begin
                for (int i = 0; i < N; i++)
                    bus.quantized_coeffs_out[i / BLOCK_SIZE][i % BLOCK_SIZE]
                        <= (i == N - 1) ? q_val : res[i];
            end
        end
    end
endmodule

// File: tb/tb_compress_block.sv
// Randomized bench for compress_block: a cycle-count model with an integer DCT and
// quantizer predicts busy, block_done and the coefficient array every cycle.
module tb_compress_block;
    localparam int B = 8;
    localparam real PI = 3.14159265358979323846;

    typedef logic [B-1:0][B-1:0][7:0] pix_t;
    typedef logic [B-1:0][B-1:0][3:0] qs_t;

    logic clk = 1'b0;
    logic rst;

    compress_block_if #(.BLOCK_SIZE(8), .PIXEL_WIDTH(8), .COEFF_WIDTH(9)) bus ();

    compress_block #(
        .BLOCK_SIZE(8), .PIXEL_WIDTH(8), .COEFF_WIDTH(9), .COS_WIDTH(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int cosv [8][8];

    int m_out  [64];
    int m_pend [64];
    int m_tmp  [64];
    int m_t00, m_f00;
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    int m_cnt    = 0;
    int cmp_idx;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void init_cos();
        real a, c;
        for (int u = 0; u < 8; u++)
            for (int x = 0; x < 8; x++) begin
                a = (u == 0) ? $sqrt(1.0 / 8.0) : 0.5;
                c = 2048.0 * a * $cos((2.0 * x + 1.0) * u * PI / 16.0);
                cosv[u][x] = (c >= 0.0) ? $rtoi($floor(c + 0.5)) : -$rtoi($floor(-c + 0.5));
            end
    endfunction

    function automatic void model_block(input pix_t p, input qs_t q, output int res[64],
                                        output int t00, output int f00);
        longint t [8][8];
        longint acc, f, val;
        int sh;
        for (int r = 0; r < 8; r++)
            for (int u = 0; u < 8; u++) begin
                acc = 0;
                for (int x = 0; x < 8; x++)
                    acc += longint'(int'(p[r][x]) - 128) * cosv[u][x];
                t[r][u] = (acc + 1024) >>> 11;
            end
        f00 = 0;
        for (int v = 0; v < 8; v++)
            for (int u = 0; u < 8; u++) begin
                acc = 0;
                for (int y = 0; y < 8; y++) acc += t[y][u] * cosv[v][y];
                f  = (acc + 1024) >>> 11;
                sh = (q[v][u] > 11) ? 11 : int'(q[v][u]);
                val = (sh == 0) ? f : ((f + (longint'(1) << (sh - 1))) >>> sh);
                if (val > 255)  val = 255;
                if (val < -256) val = -256;
                res[v * 8 + u] = int'(val);
                if (v == 0 && u == 0) f00 = int'(f);
            end
        t00 = int'(t[0][0]);
    endfunction

    function automatic int dut_coeff(input int idx);
        return int'($signed(bus.quantized_coeffs_out[idx / 8][idx % 8]));
    endfunction

    function automatic int nonzero_count();
        int n = 0;
        for (int i = 0; i < 64; i++) if (dut_coeff(i) != 0) n++;
        return n;
    endfunction

    function automatic pix_t flat(input logic [7:0] val);
        pix_t p;
        for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) p[y][x] = val;
        return p;
    endfunction

    function automatic pix_t rand_pix();
        pix_t p;
        for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) p[y][x] = 8'($urandom_range(0, 255));
        return p;
    endfunction

    function automatic qs_t rand_qs();
        qs_t q;
        for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) q[y][x] = 4'($urandom_range(0, 15));
        return q;
    endfunction

    // Model: accept when idle, publish 128 edges later, go idle one edge after that.
    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_cnt    <= 0;
            for (int i = 0; i < 64; i++) m_out[i] <= 0;
        end else if (!m_active) begin
            m_done <= 1'b0;
            if (bus.start_block === 1'b1) begin
                model_block(bus.pixels_in, bus.quant_shift, m_tmp, m_t00, m_f00);
                m_pend   <= m_tmp;
                m_active <= 1'b1;
                m_cnt    <= 0;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 127) begin
                m_out  <= m_pend;
                m_done <= 1'b1;
            end else if (m_cnt == 128) begin
                m_done   <= 1'b0;
                m_active <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_idx = 0;
            for (int i = 63; i >= 0; i--) if (dut_coeff(i) != m_out[i]) cmp_idx = i;
            chk("busy", (bus.busy === 1'b1) ? 1 : 0, int'(m_active));
            chk("block_done", (bus.block_done === 1'b1) ? 1 : 0, int'(m_done));
            chk($sformatf("coeff[%0d][%0d]", cmp_idx / 8, cmp_idx % 8),
                dut_coeff(cmp_idx), m_out[cmp_idx]);
        end
    end

    task automatic run_block(input pix_t p, input qs_t q, input string nm);
        int lat;
        @(negedge clk);
        bus.pixels_in   = p;
        bus.quant_shift = q;
        bus.start_block = 1'b1;
        @(negedge clk);
        bus.start_block = 1'b0;
        bus.pixels_in   = rand_pix();
        bus.quant_shift = rand_qs();
        lat = 1;
        while (bus.block_done !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, 129);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pix_t p;
        qs_t  q;
        int   res [64];
        int   t00, f00, n, dones;

        init_cos();
        chk("rom C[0][0]", cosv[0][0], 724);
        chk("rom C[1][0]", cosv[1][0], 1004);
        chk("rom C[7][1]", cosv[7][1], -569);
        q = '0;
        model_block(flat(8'd255), q, res, t00, f00);
        chk("model flat255 T00", t00, 359);
        chk("model flat255 F00", f00, 1015);
        chk("model flat255 Q00", res[0], 255);
        chk("model flat255 Q11", res[9], 0);
        model_block(flat(8'd0), q, res, t00, f00);
        chk("model flat0 T00", t00, -362);
        chk("model flat0 F00", f00, -1024);
        chk("model flat0 Q00", res[0], -256);
        q[0][0] = 4'd2;
        model_block(flat(8'd255), q, res, t00, f00);
        chk("model flat255 sh2 Q00", res[0], 254);
        model_block(flat(8'd0), q, res, t00, f00);
        chk("model flat0 sh2 Q00", res[0], -256);

        rst             = 1'b1;
        bus.start_block = 1'b1;
        bus.pixels_in   = flat(8'd255);
        bus.quant_shift = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset busy", int'(bus.busy), 0);
        chk("reset block_done", int'(bus.block_done), 0);
        chk("reset coeffs nonzero", nonzero_count(), 0);
        rst             = 1'b0;
        bus.start_block = 1'b0;
        @(negedge clk);
        chk("no accept during reset", int'(bus.busy), 0);

        run_block(flat(8'd128), '0, "flat128");
        chk("flat128 nonzero", nonzero_count(), 0);
        run_block(flat(8'd255), '0, "flat255");
        chk("flat255 Q00", dut_coeff(0), 255);
        chk("flat255 nonzero", nonzero_count(), 1);
        q = '0; q[0][0] = 4'd2;
        run_block(flat(8'd255), q, "flat255 sh2");
        chk("flat255 sh2 Q00", dut_coeff(0), 254);
        run_block(flat(8'd0), '0, "flat0");
        chk("flat0 Q00", dut_coeff(0), -256);
        run_block(flat(8'd0), q, "flat0 sh2");
        chk("flat0 sh2 Q00", dut_coeff(0), -256);
        chk("flat0 sh2 nonzero", nonzero_count(), 1);

        // Start pulses while busy and during DONE must be dropped, not queued.
        @(negedge clk);
        bus.pixels_in   = flat(8'd255);
        bus.quant_shift = '0;
        bus.start_block = 1'b1;
        @(negedge clk);
        bus.start_block = 1'b0;
        n = 1;
        dones = 0;
        while (n < 129) begin
            @(negedge clk);
            n++;
            if (bus.block_done === 1'b1) dones++;
            if (n == 40) begin
                bus.start_block = 1'b1;
                bus.pixels_in   = flat(8'd0);
            end else begin
                bus.start_block = 1'b0;
            end
        end
        chk("inflight done at 129", int'(bus.block_done), 1);
        chk("inflight Q00", dut_coeff(0), 255);
        bus.start_block = 1'b1;
        bus.pixels_in   = flat(8'd0);
        @(negedge clk);
        bus.start_block = 1'b0;
        if (bus.block_done === 1'b1) dones++;
        chk("start in DONE ignored", int'(bus.busy), 0);
        chk("inflight single done", dones, 1);
        @(negedge clk);
        bus.pixels_in   = flat(8'd128);
        bus.start_block = 1'b1;
        @(negedge clk);
        bus.start_block = 1'b0;
        chk("start after DONE accepted", int'(bus.busy), 1);
        n = 1;
        while (bus.block_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("post-inflight latency", n, 129);
        chk("post-inflight Q00", dut_coeff(0), 0);

        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) p[y][x] = ((x + y) % 2 == 1) ? 8'd255 : 8'd0;
        run_block(p, '0, "checker");
        for (int i = 0; i < 8; i++) run_block(rand_pix(), rand_qs(), "random");

        @(negedge clk);
        bus.pixels_in   = rand_pix();
        bus.quant_shift = '0;
        bus.start_block = 1'b1;
        @(negedge clk);
        bus.start_block = 1'b0;
        n = 1;
        while (n < 70) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset busy", int'(bus.busy), 0);
        chk("midreset block_done", int'(bus.block_done), 0);
        chk("midreset nonzero", nonzero_count(), 0);
        dones = 0;
        repeat (140) begin
            @(negedge clk);
            if (bus.block_done === 1'b1) dones++;
        end
        chk("midreset no done", dones, 0);
        run_block(flat(8'd0), '0, "after reset");
        chk("after reset Q00", dut_coeff(0), -256);

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
